// File: rtl/multiply_pipe.sv
// Pipelined per-lane multiplier with dot-product sum, signed/unsigned per transaction.
// Products and sum are formed before the first register; later stages only delay them.
module multiply_pipe #(
  parameter int Ndata = 4,
  parameter int Nbits = 8,
  parameter int LAT   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  mode_signed,
  input  logic [Nbits*Ndata-1:0]                multiplier,
  input  logic [Nbits*Ndata-1:0]                multiplicand,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2*Nbits*Ndata-1:0]              mult_out,
  output logic [2*Nbits+$clog2(Ndata)-1:0]      sum_out,
  output logic                                  out_signed
);

  localparam int PW   = 2 * Nbits;
  localparam int SUMW = 2 * Nbits + $clog2(Ndata);

  function automatic logic signed [PW-1:0] ext_lane(input logic [Nbits-1:0] x,
                                                    input logic sgn);
    if (sgn) return PW'($signed(x));
    else     return PW'($unsigned(x));
  endfunction

  function automatic logic signed [SUMW-1:0] ext_prod(input logic [PW-1:0] p,
                                                      input logic sgn);
    if (sgn) return SUMW'($signed(p));
    else     return SUMW'($unsigned(p));
  endfunction

  logic [PW*Ndata-1:0] prod_c;
  logic [SUMW-1:0]     sum_c;
  logic                adv;

  logic                vld_p  [LAT];
  logic [PW*Ndata-1:0] mult_p [LAT];
  logic [SUMW-1:0]     sum_p  [LAT];
  logic                sgn_p  [LAT];

  // Truncating the PW x PW product to PW bits is exact in both modes.
  always_comb begin
    prod_c = '0;
    sum_c  = '0;
    for (int i = 0; i < Ndata; i++) begin
      prod_c[PW*i +: PW] = ext_lane(multiplier[Nbits*i +: Nbits], mode_signed)
                         * ext_lane(multiplicand[Nbits*i +: Nbits], mode_signed);
      sum_c = sum_c + ext_prod(prod_c[PW*i +: PW], mode_signed);
    end
  end

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        vld_p[k]  <= 1'b0;
        mult_p[k] <= '0;
        sum_p[k]  <= '0;
        sgn_p[k]  <= 1'b0;
      end
    end else if (adv) begin
      // stage 0: capture products and sum at acceptance
      vld_p[0]  <= in_valid && in_ready;
      mult_p[0] <= prod_c;
      sum_p[0]  <= sum_c;
      sgn_p[0]  <= mode_signed;
      // stages 1..LAT-1: pure delay, bubbles kept in place
      for (int k = 1; k < LAT; k++) begin
        vld_p[k]  <= vld_p[k-1];
        mult_p[k] <= mult_p[k-1];
        sum_p[k]  <= sum_p[k-1];
        sgn_p[k]  <= sgn_p[k-1];
      end
    end
  end

  assign out_valid  = vld_p[LAT-1];
  assign mult_out   = mult_p[LAT-1];
  assign sum_out    = sum_p[LAT-1];
  assign out_signed = sgn_p[LAT-1];

endmodule

// File: tb/tb_multiply_pipe.sv
// Self-checking bench for multiply_pipe: directed corner cases plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_multiply_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, mode_signed, out_valid, out_ready, out_signed;
  logic [31:0] multiplier, multiplicand;
  logic [63:0] mult_out;
  logic [17:0] sum_out;

  logic        s_valid, s_mode, r1_ready, r4_ready, v1, v4, sg1, sg4;
  logic [7:0]  s_a, s_b;
  logic [15:0] m1, m4, su1, su4;

  multiply_pipe #(.Ndata(4), .Nbits(8), .LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode_signed(mode_signed), .multiplier(multiplier), .multiplicand(multiplicand),
    .out_valid(out_valid), .out_ready(out_ready), .mult_out(mult_out),
    .sum_out(sum_out), .out_signed(out_signed));

  multiply_pipe #(.Ndata(1), .Nbits(8), .LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r1_ready),
    .mode_signed(s_mode), .multiplier(s_a), .multiplicand(s_b),
    .out_valid(v1), .out_ready(1'b1), .mult_out(m1), .sum_out(su1), .out_signed(sg1));

  multiply_pipe #(.Ndata(1), .Nbits(8), .LAT(4)) dut_l4 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r4_ready),
    .mode_signed(s_mode), .multiplier(s_a), .multiplicand(s_b),
    .out_valid(v4), .out_ready(1'b1), .mult_out(m4), .sum_out(su4), .out_signed(sg4));

  typedef struct packed {
    logic [63:0] m;
    logic [17:0] sum;
    logic        s;
  } exp_t;

  exp_t        q[$];
  exp_t        exp_e;
  int          total = 0;
  int          bad = 0;
  int          extra = 0;
  logic        acc, con, popped;
  logic        got_v, got_ir, got_sg;
  logic [63:0] got_m;
  logic [17:0] got_sum;

  // Reference: plain integer products of the lane values, 8-bit lanes.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input int nd, output logic [63:0] m, output logic [17:0] sum);
    longint tot, x, y, p;
    tot = 0;
    m = '0;
    for (int i = 0; i < nd; i++) begin
      x = longint'(a[8*i +: 8]);
      y = longint'(b[8*i +: 8]);
      if (s && x > 127) x = x - 256;
      if (s && y > 127) y = y - 256;
      p = x * y;
      m[16*i +: 16] = p[15:0];
      tot = tot + p;
    end
    sum = tot[17:0];
  endfunction

  // One clock on the main DUT: drive, sample before the edge, update the scoreboard.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ordy);
    exp_t e;
    in_valid = iv; multiplier = a; multiplicand = b; mode_signed = s; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    got_v = out_valid; got_ir = in_ready; got_m = mult_out; got_sum = sum_out;
    got_sg = out_signed;
    @(negedge clk);
    popped = 1'b0;
    if (con) begin
      if (q.size() == 0) extra++;
      else begin exp_e = q.pop_front(); popped = 1'b1; end
    end
    if (acc) begin
      model(a, b, s, 4, e.m, e.sum);
      e.s = s;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mult_out !== 64'd0 || sum_out !== 18'd0 || out_signed !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b m=%h s=%h sg=%b want all 0", out_valid, mult_out, sum_out, out_signed);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_unsigned();
    cycle(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL unsigned_early got v=%b want 0", out_valid); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || mult_out !== {4{16'hFE01}} || sum_out !== 18'd260100 || out_signed !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_const got v=%b m=%h s=%0d sg=%b want 1 fe01x4 260100 0", out_valid, mult_out, sum_out, out_signed);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    total++;
    if (!popped || got_m !== exp_e.m || got_sum !== exp_e.sum || got_sg !== exp_e.s) begin
      bad++;
      $display("FAIL unsigned_model got m=%h s=%h want m=%h s=%h", got_m, got_sum, exp_e.m, exp_e.sum);
    end
  endtask

  task automatic test_signed();
    cycle(1'b1, 32'h007FFF80, 32'hFB7F7F80, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || mult_out !== 64'h0000_3F01_FF81_4000 || sum_out !== 18'd32386 || out_signed !== 1'b1) begin
      bad++;
      $display("FAIL signed_const got v=%b m=%h s=%0d sg=%b want 1 00003f01ff814000 32386 1", out_valid, mult_out, sum_out, out_signed);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    total++;
    if (!popped || got_m !== exp_e.m || got_sum !== exp_e.sum || got_sg !== exp_e.s) begin
      bad++;
      $display("FAIL signed_model got m=%h s=%h want m=%h s=%h", got_m, got_sum, exp_e.m, exp_e.sum);
    end
  endtask

  task automatic test_mode_mix();
    int n;
    n = 0;
    cycle(1'b1, 32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (popped) begin
        n++;
        total++;
        if (n == 1 && (got_m !== {4{16'h01FE}} || got_sum !== 18'd2040 || got_sg !== 1'b0)) begin
          bad++;
          $display("FAIL mix_unsigned got m=%h s=%h sg=%b want 01fex4 2040 0", got_m, got_sum, got_sg);
        end
        if (n == 2 && (got_m !== {4{16'hFFFE}} || got_sum !== 18'h3FFF8 || got_sg !== 1'b1)) begin
          bad++;
          $display("FAIL mix_signed got m=%h s=%h sg=%b want fffex4 3fff8 1", got_m, got_sum, got_sg);
        end
      end
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL mix_count got %0d want 2", n); end
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    logic ordy, stall, prev_stall, prev_sg;
    logic [63:0] prev_m;
    logic [17:0] prev_sum;
    sent = 0; recv = 0; prev_stall = 1'b0;
    prev_m = '0; prev_sum = '0; prev_sg = 1'b0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      ordy = !(c >= 4 && c < 9);
      cycle(sent < 10, $urandom, $urandom, 1'($urandom_range(0, 1)), ordy);
      stall = got_v && !ordy;
      if (stall) begin
        total++;
        if (got_ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, got_ir); end
      end
      if (prev_stall) begin
        total++;
        if (got_v !== 1'b1 || got_m !== prev_m || got_sum !== prev_sum || got_sg !== prev_sg) begin
          bad++;
          $display("FAIL stall_hold c=%0d got m=%h s=%h want m=%h s=%h", c, got_m, got_sum, prev_m, prev_sum);
        end
      end
      if (acc) sent++;
      if (popped) begin
        recv++;
        total++;
        if (got_m !== exp_e.m || got_sum !== exp_e.sum || got_sg !== exp_e.s) begin
          bad++;
          $display("FAIL stream_data #%0d got m=%h s=%h sg=%b want m=%h s=%h sg=%b", recv, got_m, got_sum, got_sg, exp_e.m, exp_e.sum, exp_e.s);
        end
      end
      prev_stall = stall; prev_m = got_m; prev_sum = got_sum; prev_sg = got_sg;
    end
    total++;
    if (sent != 10 || recv != 10 || extra != 0) begin
      bad++;
      $display("FAIL stream_count got sent=%0d recv=%0d extra=%0d want 10 10 0", sent, recv, extra);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL midflight_fill got v=%b want 1", out_valid); end
    rst = 1'b1;
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || mult_out !== 64'd0 || sum_out !== 18'd0 || out_signed !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midflight_reset got v=%b m=%h s=%h sg=%b rdy=%b want 0", out_valid, mult_out, sum_out, out_signed, in_ready);
    end
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (got_v !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || extra != 0) begin bad++; $display("FAIL midflight_ghost got %0d stale results want 0", seen); end
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_new_early got v=%b want 0", out_valid); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL midflight_new_latency got v=%b want 1", out_valid); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    total++;
    if (!popped || got_m !== exp_e.m || got_sum !== exp_e.sum || got_sg !== exp_e.s || q.size() != 0) begin
      bad++;
      $display("FAIL midflight_new_data got m=%h s=%h want m=%h s=%h", got_m, got_sum, exp_e.m, exp_e.sum);
    end
  endtask

  task automatic test_throughput();
    logic [7:0]  ta[20];
    logic [7:0]  tb[20];
    logic        tm[20];
    logic [63:0] em;
    logic [17:0] es;
    logic        v, sg, expv;
    logic [15:0] m, su;
    int          lat, idx;
    for (int i = 0; i < 20; i++) begin
      ta[i] = 8'($urandom); tb[i] = 8'($urandom); tm[i] = 1'($urandom_range(0, 1));
    end
    ta[0] = 8'h80; tb[0] = 8'h80; tm[0] = 1'b1;
    ta[1] = 8'hFF; tb[1] = 8'hFF; tm[1] = 1'b0;
    for (int j = 0; j < 24; j++) begin
      s_valid = (j < 20);
      if (j < 20) begin s_a = ta[j]; s_b = tb[j]; s_mode = tm[j]; end
      #1;
      total++;
      if (r1_ready !== 1'b1 || r4_ready !== 1'b1) begin
        bad++; $display("FAIL tp_ready j=%0d got %b%b want 11", j, r1_ready, r4_ready);
      end
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? 1 : 4;
        v   = (d == 0) ? v1 : v4;
        m   = (d == 0) ? m1 : m4;
        su  = (d == 0) ? su1 : su4;
        sg  = (d == 0) ? sg1 : sg4;
        idx = j - lat;
        expv = (idx >= 0 && idx < 20);
        total++;
        if (v !== expv) begin bad++; $display("FAIL tp_valid lat=%0d j=%0d got %b want %b", lat, j, v, expv); end
        if (expv) begin
          model({24'd0, ta[idx]}, {24'd0, tb[idx]}, tm[idx], 1, em, es);
          total++;
          if (m !== em[15:0] || su !== es[15:0] || su !== m || sg !== tm[idx]) begin
            bad++;
            $display("FAIL tp_data lat=%0d #%0d got m=%h s=%h sg=%b want m=%h s=%h sg=%b", lat, idx, m, su, sg, em[15:0], es[15:0], tm[idx]);
          end
        end
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode_signed = 1'b0;
    multiplier = '0; multiplicand = '0;
    s_valid = 1'b0; s_mode = 1'b0; s_a = '0; s_b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_mode_mix();
    test_back_to_back();
    test_reset_midflight();
    test_throughput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
